// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the EX writeback (no backpressure) and the buffered MEM
// writeback onto one register-file write port, and serves ID-stage
// forwarding lookups from every in-flight write.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        ex_wb_en_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic        mem_wb_valid_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [31:0] mem_rd_data_i,
  output logic        mem_wb_ready_o,
  output logic        regs_wb_en_o,
  output logic [4:0]  regs_rd_addr_o,
  output logic [31:0] regs_rd_data_o,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  output logic        fwd_rs1_hit_o,
  output logic        fwd_rs2_hit_o,
  output logic [31:0] fwd_rs1_data_o,
  output logic [31:0] fwd_rs2_data_o,
  output logic [15:0] conflict_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // The queue is kept compacted: slot 0 is always the head and slots
  // [0, count) are all live, so squashing a middle entry just closes the gap.
  logic [4:0]    q_addr   [FIFO_DEPTH];
  logic [31:0]   q_data   [FIFO_DEPTH];
  logic [4:0]    q_addr_n [FIFO_DEPTH];
  logic [31:0]   q_data_n [FIFO_DEPTH];
  logic [CW-1:0] count, count_n;
  logic [15:0]   cnt_q;

  logic ex_w, mem_nz, acc, mem_keep, head_vld, pop, fall, push;

  // Handshake and write-port arbitration: EX, then FIFO head, then fall-through.
  always_comb begin
    ex_w           = ex_wb_en_i && (ex_rd_addr_i != 5'd0);
    mem_nz         = (mem_rd_addr_i != 5'd0);
    mem_wb_ready_o = rest && (count < DEPTH_C);
    acc            = mem_wb_valid_i && mem_wb_ready_o;
    // x0 and requests overwritten by a same-rd EX write complete but vanish
    mem_keep       = acc && mem_nz && !(ex_w && (mem_rd_addr_i == ex_rd_addr_i));
    head_vld       = (count != '0);
    pop            = !ex_w && head_vld;
    fall           = !ex_w && !head_vld && mem_keep;
    push           = mem_keep && !fall;
    regs_wb_en_o   = 1'b0;
    regs_rd_addr_o = 5'd0;
    regs_rd_data_o = 32'd0;
    if (!rest) begin
      regs_wb_en_o = 1'b0;
    end else if (ex_w) begin
      regs_wb_en_o   = 1'b1;
      regs_rd_addr_o = ex_rd_addr_i;
      regs_rd_data_o = ex_rd_data_i;
    end else if (head_vld) begin
      regs_wb_en_o   = 1'b1;
      regs_rd_addr_o = q_addr[0];
      regs_rd_data_o = q_data[0];
    end else if (fall) begin
      regs_wb_en_o   = 1'b1;
      regs_rd_addr_o = mem_rd_addr_i;
      regs_rd_data_o = mem_rd_data_i;
    end
  end

  // Next queue contents: drop popped head and EX-squashed entries, then append.
  always_comb begin
    int n;
    q_addr_n = q_addr;
    q_data_n = q_data;
    n = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((i < int'(count)) && !(pop && (i == 0)) &&
          !(ex_w && (q_addr[i] == ex_rd_addr_i))) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          if (j == n) begin
            q_addr_n[j] = q_addr[i];
            q_data_n[j] = q_data[i];
          end
        end
        n = n + 1;
      end
    end
    if (push) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (j == n) begin
          q_addr_n[j] = mem_rd_addr_i;
          q_data_n[j] = mem_rd_data_i;
        end
      end
      n = n + 1;
    end
    count_n = CW'(n);
  end

  // Queue state and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (!rest) begin
      count <= '0;
      cnt_q <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_addr[i] <= 5'd0;
        q_data[i] <= 32'd0;
      end
    end else begin
      count  <= count_n;
      q_addr <= q_addr_n;
      q_data <= q_data_n;
      if (ex_w && mem_wb_valid_i && mem_nz && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = cnt_q;

  // Youngest write wins: EX, then incoming MEM, then queue tail toward head.
  function automatic logic [32:0] lookup(input logic [4:0] rs);
    logic [32:0] res;
    res = '0;
    if (rs != 5'd0) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if ((i < int'(count)) && (q_addr[i] == rs)) res = {1'b1, q_data[i]};
      if (mem_wb_valid_i && (mem_rd_addr_i == rs)) res = {1'b1, mem_rd_data_i};
      if (ex_w && (ex_rd_addr_i == rs)) res = {1'b1, ex_rd_data_i};
    end
    return res;
  endfunction

  // Forwarding results, forced to zero during reset.
  always_comb begin
    {fwd_rs1_hit_o, fwd_rs1_data_o} = rest ? lookup(id_rs1_addr_i) : 33'd0;
    {fwd_rs2_hit_o, fwd_rs2_data_o} = rest ? lookup(id_rs2_addr_i) : 33'd0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scenario tasks with a write-port scoreboard; expected
// register writes are queued as stimulus is driven and popped as they appear.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rest;
  logic        ex_wb_en_i;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        mem_wb_valid_i;
  logic [4:0]  mem_rd_addr_i;
  logic [31:0] mem_rd_data_i;
  logic        mem_wb_ready_o;
  logic        regs_wb_en_o;
  logic [4:0]  regs_rd_addr_o;
  logic [31:0] regs_rd_data_o;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        fwd_rs1_hit_o;
  logic        fwd_rs2_hit_o;
  logic [31:0] fwd_rs1_data_o;
  logic [31:0] fwd_rs2_data_o;
  logic [15:0] conflict_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rest(rest),
    .ex_wb_en_i(ex_wb_en_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
    .mem_wb_valid_i(mem_wb_valid_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_data_i(mem_rd_data_i),
    .mem_wb_ready_o(mem_wb_ready_o),
    .regs_wb_en_o(regs_wb_en_o), .regs_rd_addr_o(regs_rd_addr_o), .regs_rd_data_o(regs_rd_data_o),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .fwd_rs1_hit_o(fwd_rs1_hit_o), .fwd_rs2_hit_o(fwd_rs2_hit_o),
    .fwd_rs1_data_o(fwd_rs1_data_o), .fwd_rs2_data_o(fwd_rs2_data_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed register write must match the oldest expected one.
  always @(negedge clk) begin
    if (regs_wb_en_o === 1'b1) begin
      logic [36:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got x%0d=%h, required no write", regs_rd_addr_o, regs_rd_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({regs_rd_addr_o, regs_rd_data_o} !== e) begin
          n_fail++;
          $display("FAIL wb_order: got x%0d=%h, required x%0d=%h",
                   regs_rd_addr_o, regs_rd_data_o, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic set_in(input logic ee, input logic [4:0] ea, input logic [31:0] ed,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(posedge clk); #1;
    ex_wb_en_i = ee; ex_rd_addr_i = ea; ex_rd_data_i = ed;
    mem_wb_valid_i = mv; mem_rd_addr_i = ma; mem_rd_data_i = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rest = 1'b0;
    id_rs1_addr_i = 5'd5; id_rs2_addr_i = 5'd6;
    set_in(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'hBEEF);
    @(negedge clk);
    n_checks++;
    if ({regs_wb_en_o, mem_wb_ready_o, fwd_rs1_hit_o, fwd_rs2_hit_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 0000",
                         {regs_wb_en_o, mem_wb_ready_o, fwd_rs1_hit_o, fwd_rs2_hit_o});
    end
    n_checks++;
    if ({regs_rd_addr_o, regs_rd_data_o, fwd_rs1_data_o, fwd_rs2_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr %0d data %h f1 %h f2 %h, required 0",
                         regs_rd_addr_o, regs_rd_data_o, fwd_rs1_data_o, fwd_rs2_data_o);
    end
    n_checks++;
    if (conflict_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d, required 0", conflict_cnt_o);
    end
    idle();
    rest = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_mem_only();
    exp_q.push_back({5'd3, 32'h11});
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
    @(negedge clk);
    n_checks++;
    if (regs_wb_en_o !== 1'b1 || mem_wb_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mem_fallthrough: got en %b ready %b, required 1 1", regs_wb_en_o, mem_wb_ready_o);
    end
    idle(); idle();
  endtask

  task automatic test_conflict();
    exp_q.push_back({5'd4, 32'hA});
    exp_q.push_back({5'd5, 32'hB});
    id_rs1_addr_i = 5'd4; id_rs2_addr_i = 5'd5;
    set_in(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB);
    exp_cnt++;
    @(negedge clk);
    n_checks++;
    if ({fwd_rs1_hit_o, fwd_rs1_data_o, fwd_rs2_hit_o, fwd_rs2_data_o} !== {1'b1, 32'hA, 1'b1, 32'hB}) begin
      n_fail++; $display("FAIL fwd_ex_mem: got %b %h %b %h, required 1 a 1 b",
                         fwd_rs1_hit_o, fwd_rs1_data_o, fwd_rs2_hit_o, fwd_rs2_data_o);
    end
    id_rs1_addr_i = 5'd5;
    idle();
    @(negedge clk);
    n_checks++;
    if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'hB) begin
      n_fail++; $display("FAIL fwd_fifo: got %b %h, required 1 b", fwd_rs1_hit_o, fwd_rs1_data_o);
    end
    n_checks++;
    if (conflict_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL conflict_cnt: got %0d, required %0d", conflict_cnt_o, exp_cnt);
    end
    idle();
  endtask

  task automatic test_fill();
    logic [5:0] exp_rdy;
    exp_rdy = 6'b100011;  // bit c = ready expected in cycle c
    for (int c = 0; c < 6; c++) begin
      logic        ee;
      logic [4:0]  ea, ma;
      logic [31:0] md;
      ee = (c < 4);
      ea = ee ? 5'(10 + c) : 5'd0;
      ma = (c == 0) ? 5'd6 : (c == 1) ? 5'd7 : 5'd9;
      md = (c == 0) ? 32'h66 : (c == 1) ? 32'h77 : 32'h99;
      if (ee) begin
        exp_q.push_back({ea, 32'(c + 1)});
        exp_cnt++;
      end
      if (c == 4) exp_q.push_back({5'd6, 32'h66});
      if (c == 5) exp_q.push_back({5'd7, 32'h77});
      set_in(ee, ea, 32'(c + 1), 1'b1, ma, md);
      @(negedge clk);
      n_checks++;
      if (mem_wb_ready_o !== exp_rdy[c]) begin
        n_fail++; $display("FAIL fill_ready c%0d: got %b, required %b", c, mem_wb_ready_o, exp_rdy[c]);
      end
    end
    exp_q.push_back({5'd9, 32'h99});
    idle(); idle();
    @(negedge clk);
    n_checks++;
    if (conflict_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL fill_cnt: got %0d, required %0d", conflict_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_squash();
    exp_q.push_back({5'd21, 32'h33});
    set_in(1'b1, 5'd21, 32'h33, 1'b1, 5'd8, 32'h1);
    exp_cnt++;
    exp_q.push_back({5'd8, 32'h2});
    id_rs1_addr_i = 5'd8;
    set_in(1'b1, 5'd8, 32'h2, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h2) begin
      n_fail++; $display("FAIL squash_fwd: got %b %h, required 1 2", fwd_rs1_hit_o, fwd_rs1_data_o);
    end
    // same-rd MEM request alongside EX is accepted and dropped
    exp_q.push_back({5'd15, 32'h7});
    set_in(1'b1, 5'd15, 32'h7, 1'b1, 5'd15, 32'h8);
    exp_cnt++;
    @(negedge clk);
    n_checks++;
    if (mem_wb_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL drop_ready: got %b, required 1", mem_wb_ready_o);
    end
    idle(); idle();
    @(negedge clk);
    n_checks++;
    if (conflict_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL squash_cnt: got %0d, required %0d", conflict_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_x0();
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    set_in(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
    @(negedge clk);
    n_checks++;
    if (regs_wb_en_o !== 1'b0 || mem_wb_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL x0_write: got en %b ready %b, required 0 1", regs_wb_en_o, mem_wb_ready_o);
    end
    n_checks++;
    if ({fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs2_data_o} !== 34'd0) begin
      n_fail++; $display("FAIL x0_fwd: got %b %b %h, required 0 0 0", fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs2_data_o);
    end
    idle(); idle();
    @(negedge clk);
    n_checks++;
    if (conflict_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL x0_cnt: got %0d, required %0d", conflict_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({5'd22, 32'h22});
    set_in(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    exp_q.push_back({5'd24, 32'h24});
    set_in(1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25);
    @(posedge clk); #1;
    rest = 1'b0;
    ex_wb_en_i = 1'b0; mem_wb_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_wb_ready_o !== 1'b0 || regs_wb_en_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ready: got ready %b en %b, required 0 0", mem_wb_ready_o, regs_wb_en_o);
    end
    @(posedge clk); #1;
    rest = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    n_checks++;
    if (mem_wb_ready_o !== 1'b1 || conflict_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_state: got ready %b cnt %0d, required 1 0", mem_wb_ready_o, conflict_cnt_o);
    end
    idle(); idle(); idle();
  endtask

  initial begin
    rest = 1'b0;
    ex_wb_en_i = 1'b0; ex_rd_addr_i = 5'd0; ex_rd_data_i = 32'd0;
    mem_wb_valid_i = 1'b0; mem_rd_addr_i = 5'd0; mem_rd_data_i = 32'd0;
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    test_reset();
    test_mem_only();
    test_conflict();
    test_fill();
    test_squash();
    test_x0();
    test_reset_mid();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
